// File: rtl/posit_dec_arbiter.sv
// posit_dec_arbiter: round-robin sharing of one posit pair decoder among NREQ requesters,
// with a per-owner burst quantum, a registered issue stage and an id tag pipeline matched to decode latency.
module posit_dec_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int QUANTUM = 4,
    parameter int DEC_LAT = 1
) (
    input  logic                      clk_i,
    input  logic                      rstn,
    input  logic                      en_i,
    input  logic [NREQ-1:0]           mask_i,
    input  logic [NREQ-1:0]           req_vld_i,
    input  logic [NREQ*WIDTH-1:0]     req_win_i,
    input  logic [NREQ*WIDTH-1:0]     req_din_i,
    output logic [NREQ-1:0]           req_rdy_o,
    output logic [WIDTH-1:0]          dec_win_o,
    output logic [WIDTH-1:0]          dec_din_o,
    output logic                      dec_vld_o,
    output logic                      rsp_vld_o,
    output logic [$clog2(NREQ)-1:0]   rsp_id_o,
    output logic                      busy_o,
    output logic                      done_o
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   owner, gnt_idx, idx;
    logic [3:0]      burst_cnt;
    logic [NREQ-1:0] elig;
    logic            keep, xfer, drained;
    logic [DEC_LAT:0] tag_vld;
    logic [IW-1:0]   tag_id [DEC_LAT+1];

    assign elig = req_vld_i & mask_i & {NREQ{state == RUN}};
    // burst_cnt of zero means nobody owns the decoder yet, so the first search starts at owner+1
    assign keep = elig[owner] && burst_cnt != 4'd0 && burst_cnt < 4'(QUANTUM);

    always_comb begin
        gnt_idx = owner;
        xfer    = keep;
        idx     = owner;
        if (!keep)
            for (int k = 1; k <= NREQ; k++) begin
                idx = IW'((int'(owner) + k) % NREQ);
                if (!xfer && elig[idx]) begin
                    xfer    = 1'b1;
                    gnt_idx = idx;
                end
            end
    end

    assign req_rdy_o = xfer ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
    assign drained   = !dec_vld_o && !(|tag_vld);

    always_comb begin
        state_nxt = state;
        done_o    = 1'b0;
        state_nxt = state == IDLE ? (en_i ? RUN : IDLE) :
                    state == RUN  ? (en_i ? RUN : DRAIN) :
                    en_i ? RUN : drained ? IDLE : DRAIN;
        done_o    = state == DRAIN && !en_i && drained;
    end

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            owner     <= IW'(NREQ - 1);
            burst_cnt <= '0;
            dec_win_o <= '0;
            dec_din_o <= '0;
            dec_vld_o <= 1'b0;
            tag_vld   <= '0;
            for (int i = 0; i <= DEC_LAT; i++) tag_id[i] <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                owner     <= gnt_idx;
                burst_cnt <= keep ? burst_cnt + 4'd1 : 4'd1;
            end
            dec_win_o  <= xfer ? req_win_i[gnt_idx*WIDTH +: WIDTH] : '0;
            dec_din_o  <= xfer ? req_din_i[gnt_idx*WIDTH +: WIDTH] : '0;
            dec_vld_o  <= xfer;
            tag_vld[0] <= xfer;
            tag_id[0]  <= xfer ? gnt_idx : '0;
            for (int i = 1; i <= DEC_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    assign rsp_vld_o = tag_vld[DEC_LAT];
    assign rsp_id_o  = tag_id[DEC_LAT];
    assign busy_o    = state != IDLE;
endmodule

// File: doc/posit_dec_arbiter.md
# posit_dec_arbiter

Round-robin scheduler that shares one posit pair decoder (weight `win`, data `din`, 1-cycle registered decode) among `NREQ` requesters. Each requester supplies `WIDTH`-bit posit pairs over a valid/ready handshake. The block grants at most one pair per cycle, with a per-owner burst quantum, and drives the decoder's `win`/`din` from a register. It tags every issued pair so the consumer can tell which requester each decoded result belongs to. The block sits between the PE-array operand fetchers and the decoder; the consumer of decoded results never stalls.

## Interface
- `WIDTH`, 8: posit width; same value as the decoder.
- `NREQ`, 4: number of requesters; must be at least 2.
- `QUANTUM`, 4: maximum consecutive grants to one owner, range 1..15.
- `DEC_LAT`, 1: decoder latency in cycles, from its input to its registered outputs.
- `clk_i` in 1: clock.
- `rstn` in 1: reset; **one clock; reset is asynchronous and active-low.**
- `en_i` in 1: run enable, level-sensitive.
- `mask_i` in NREQ: per-requester enable. A 0 bit excludes that requester from arbitration.
- `req_vld_i` in NREQ: requester i has a pair available.
- `req_win_i` in NREQ*WIDTH: weight posits; slice i is `[i*WIDTH +: WIDTH]`.
- `req_din_i` in NREQ*WIDTH: data posits, sliced the same way.
- `req_rdy_o` in/out: output, NREQ bits, one-hot grant. Requester i's pair transfers when both its valid and ready are high.
- `dec_win_o` out WIDTH: weight posit to the decoder `win` input; registered.
- `dec_din_o` out WIDTH: data posit to the decoder `din` input; registered.
- `dec_vld_o` out 1: `dec_win_o`/`dec_din_o` hold a real pair.
- `rsp_vld_o` out 1: the decoder outputs in this cycle belong to an issued pair.
- `rsp_id_o` out $clog2(NREQ): requester index for that result.
- `busy_o` out 1: state is not IDLE.
- `done_o` out 1: one-cycle pulse when DRAIN completes.

## Operation
- **States:** IDLE, RUN, DRAIN.
  - IDLE goes to RUN when `en_i` is 1.
  - RUN goes to DRAIN when `en_i` is 0.
  - DRAIN goes to IDLE when the in-flight count is 0; `done_o` pulses in that transition cycle.
  - DRAIN goes back to RUN if `en_i` returns to 1 before completion; `done_o` does not pulse.
- **Eligibility:** requester i is eligible when `req_vld_i[i]`, `mask_i[i]` and state == RUN are all true.
- **Grant logic** is combinational from eligibility, the owner register and the burst counter:
  - The current owner keeps the grant if it is eligible and `burst_cnt < QUANTUM`.
  - Otherwise the grant goes to the first eligible requester searching `owner+1, owner+2, …` modulo NREQ.
  - If the owner has used up its quantum and is the only eligible requester, it is re-granted and `burst_cnt` restarts at 1.
- **Grant register updates** (only on a transfer):
  - `owner` is set to the granted index.
  - `burst_cnt` becomes 1 on an owner change and increments otherwise.
  - In cycles with no grant, both registers hold their values.
- **Handshake:**
  - `req_rdy_o` is zero outside RUN.
  - `req_rdy_o` never asserts for a requester whose valid is low.
  - A requester may hold valid high across cycles without transferring; `req_win_i`/`req_din_i` must stay stable until the transfer happens.
- **Issue register:**
  - On a transfer, `dec_win_o`/`dec_din_o` take the granted slices and `dec_vld_o` is set to 1.
  - Otherwise `dec_win_o`/`dec_din_o` are set to 0 (the decoder sees zero) and `dec_vld_o` is set to 0.
- **Tag pipeline:** DEC_LAT+1 stages of {valid, id}, fed from the transfer event. The last stage drives `rsp_vld_o`/`rsp_id_o`. `rsp_id_o` is 0 whenever `rsp_vld_o` is 0.
- **In-flight count:** the number of valid pipeline stages plus `dec_vld_o`. DRAIN waits for this count to reach 0.
- **Mask changes** take effect in the same cycle. If the current owner becomes masked, ownership rotates immediately.

## Timing
- Transfer at edge T: the pair appears on `dec_*_o` after T; decoded results and `rsp_vld_o` appear after edge T+DEC_LAT+1. With DEC_LAT=1, results follow the transfer by 2 cycles.
- Throughput is 1 pair per cycle when any requester is eligible.
- Reset values:
  - Registers: state IDLE, `owner` = NREQ-1 (so the first grant search starts at index 0), `burst_cnt` = 0, all tag stages 0.
  - Outputs: `dec_win_o`, `dec_din_o`, `dec_vld_o`, `rsp_vld_o`, `rsp_id_o`, `busy_o` and `done_o` are all 0.
- Reset mid-operation discards in-flight tags. No `rsp_vld_o` is produced for pairs issued before reset.
- If `en_i` falls in the same cycle as a transfer, the transfer still completes because grant uses the registered state. DRAIN then covers that pair.

## Test plan
- **Single requester:** reset, `en_i`=1, `mask_i`=4'b1111, only req0 valid, win=8'h40 and din=8'hC0, for 1 cycle → `req_rdy_o`=4'b0001; `dec_win_o`=8'h40 and `dec_din_o`=8'hC0 the next cycle; `rsp_vld_o`=1 with `rsp_id_o`=0 two cycles after the transfer.
- **Fairness:** all four requesters valid continuously, QUANTUM=4 → grant sequence 0,0,0,0,1,1,1,1,2,…; 16 transfers in 16 cycles.
- **Quantum with a single requester:** QUANTUM=1, only req2 valid for 5 cycles → 5 consecutive grants to 2, no bubbles, `rsp_id_o`=2 five times.
- **Mask mid-burst:** req1 owns the grant with `burst_cnt`=2 while req1 and req3 are both valid; set `mask_i[1]`=0 → the same cycle grants 3.
- **Drain:** issue 3 pairs, drop `en_i` in the last transfer cycle → `req_rdy_o` is 0 from the next cycle; `done_o` pulses once after the last `rsp_vld_o`; `busy_o` then falls to 0.
- **Reset:** assert `rstn`=0 one cycle after a transfer → all outputs are 0 immediately; no `rsp_vld_o` appears after release.
